ecc32_encoder_tx: RTL
=====================

Name: ecc32_encoder_tx

Overview:
Transmit-side ECC 32/7 encoder for the ALCT data path. It accepts 32-bit words over a valid/ready handshake and computes the 7-bit SEC-DED Hamming parity that the ecc32 decoder checks. Each word and its parity are buffered in a 2-entry output queue and presented downstream with valid/ready flow control. The block adds one-shot error injection, for link and decoder self-test, and a count of words sent.

Parameters:
CNT_W, 16, width of the sent-word counter (saturating)

Ports:
clock  in  1  system clock, all logic on the rising edge
reset_n  in  1  asynchronous active-low reset
din  in  32  data word to encode
din_valid  in  1  din is valid
din_ready  out  1  block can accept a word this cycle
enc_data  out  32  data word, after any injection
enc_parity  out  7  parity word, after any injection
enc_valid  out  1  enc_data/enc_parity are valid
enc_ready  in  1  downstream accepts the word this cycle
inj_arm  in  1  pulse: arm error injection for the next accepted word
inj_mode  in  2  00 none, 01 single data bit, 10 double data bit, 11 single check bit
inj_bit  in  5  bit index used for injection
inj_armed  out  1  injection is armed and pending
inj_done  out  1  1-cycle pulse when the injected word is accepted downstream
cnt_clr  in  1  synchronous clear of word_cnt
word_cnt  out  CNT_W  count of words accepted downstream, saturating

Behaviour:
- Reset (async assert, sync release): queue empty; enc_valid=0; enc_data=0; enc_parity=0; din_ready=1; inj_armed=0; inj_done=0; word_cnt=0.
- Parity bits p[5:0] are XORs of din bits:
  - p0: bits 0,1,3,4,6,8,10,11,13,15,17,19,21,23,25,26,28,30
  - p1: bits 0,2,3,5,6,9,10,12,13,16,17,20,21,24,25,27,28,31
  - p2: bits 1,2,3,7,8,9,10,14,15,16,17,22,23,24,25,29,30,31
  - p3: bits 4-10 and 18-25
  - p4: bits 11-25
  - p5: bits 26-31
  - p6 = XOR of all 32 din bits XOR p[5:0] (overall parity).
- Parity is computed combinationally on din and stored with the word at the accept edge.
- Accept condition: din_valid & din_ready.
- Queue, 2 entries, each holding data[31:0], parity[6:0] and an inj flag. Occupancy is 0, 1 or 2:
  - din_ready = (occupancy != 2), decoded from registered occupancy; there is no combinational path from enc_ready.
  - enc_valid = (occupancy != 0). enc_data/enc_parity show the head entry. When the queue is empty they hold their last values (0 after reset).
  - Latency: a word accepted at edge N appears with enc_valid=1 after edge N if the queue was empty.
  - Push and pop in the same cycle at occupancy 1: occupancy stays 1 and the new word becomes head.
  - At occupancy 2 no push is possible; a pop drops occupancy to 1.
  - Order is strict FIFO. A word is never dropped or duplicated. While enc_ready=0 the head stays stable.
- Injection:
  - inj_arm=1 sets inj_armed. Arming while already armed has no effect.
  - On the next accept with inj_armed=1, the mask is applied to the stored word, the entry's inj flag is set, and inj_armed clears at the same edge.
  - If inj_arm and an accept coincide while unarmed, that word is not injected and the block stays armed.
  - Mode 01: flip data[inj_bit].
  - Mode 10: flip data[inj_bit] and data[(inj_bit+1) mod 32]; inj_bit=31 flips bits 31 and 0.
  - Mode 11: flip parity[inj_bit[2:0]]; inj_bit[2:0]=7 flips nothing.
  - Mode 00: no flip, but the word still consumes the arm and raises inj_done.
  - Mode and index are sampled at the accept edge.
  - inj_done pulses for 1 cycle after the pop edge of the flagged entry.
- word_cnt:
  - Increments on every pop (enc_valid & enc_ready) and saturates at all ones.
  - cnt_clr has priority over increment.
- Reset asserted mid-operation flushes the queue and clears any arm immediately. Words in flight are lost.

Test Plan:
- Known vectors, with enc_ready=1:
  - din=0x00000000 -> enc_parity=0x00
  - din=0x00000001 -> enc_parity=0x43
  - din=0xFFFFFFFF -> enc_parity=0x18
  - each appears 1 cycle after accept.
- Backpressure: enc_ready=0, push 3 words -> din_ready low after 2 accepts, third word held. Release enc_ready -> all 3 words out in order, none lost; word_cnt=3.
- Simultaneous push/pop at occupancy 1 for 100 back-to-back words -> occupancy stays 1, throughput 1 word/cycle, word_cnt=100.
- Injection, mode 01, inj_bit=5, din=0 -> enc_data=0x00000020, enc_parity=0x00. ecc32 decoder on that word -> error=01, dec_out=0. inj_done pulses once; the following word is clean.
- Mode 10, inj_bit=31, din=0 -> enc_data=0x80000001, decoder error=10. Mode 11, inj_bit=6 -> enc_parity=0x40, decoder error=11.
- Counter and reset: force word_cnt to saturate (CNT_W=4 build) -> holds 0xF. cnt_clr together with a pop -> 0. Async reset_n low with 2 entries queued -> enc_valid=0, din_ready=1, inj_armed=0 without waiting for a clock edge.

Source files
------------

// File: rtl/ecc32_encoder_tx.sv
// Transmit-side ECC 32/7 encoder for the ALCT data path.
// Computes SEC-DED Hamming parity for each accepted word, buffers word and
// parity in a 2-entry FIFO with valid/ready on both sides, supports one-shot
// error injection for link/decoder self-test and counts words sent.
module ecc32_encoder_tx #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [31:0]      din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [31:0]      enc_data,
    output logic [6:0]       enc_parity,
    output logic             enc_valid,
    input  logic             enc_ready,
    input  logic             inj_arm,
    input  logic [1:0]       inj_mode,
    input  logic [4:0]       inj_bit,
    output logic             inj_armed,
    output logic             inj_done,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [1:0] {
        INJ_NONE  = 2'b00,
        INJ_DATA1 = 2'b01,
        INJ_DATA2 = 2'b10,
        INJ_CHECK = 2'b11
    } inj_mode_e;

    typedef struct packed {
        logic [31:0] data;
        logic [6:0]  parity;
        logic        inj;
    } entry_t;

    // Data-bit coverage of each Hamming check bit (must match the ecc32 decoder).
    localparam logic [31:0] P0_MASK = 32'h56AA_AD5B;
    localparam logic [31:0] P1_MASK = 32'h9B33_366D;
    localparam logic [31:0] P2_MASK = 32'hE3C3_C78E;
    localparam logic [31:0] P3_MASK = 32'h03FC_07F0;
    localparam logic [31:0] P4_MASK = 32'h03FF_F800;
    localparam logic [31:0] P5_MASK = 32'hFC00_0000;

    function automatic logic [6:0] calc_parity(input logic [31:0] d);
        logic [5:0] p;
        p[0] = ^(d & P0_MASK);
        p[1] = ^(d & P1_MASK);
        p[2] = ^(d & P2_MASK);
        p[3] = ^(d & P3_MASK);
        p[4] = ^(d & P4_MASK);
        p[5] = ^(d & P5_MASK);
        // Overall parity spans data and the six Hamming bits for double-error detection.
        return {(^d) ^ (^p), p};
    endfunction

    // Slot 0 is always the head; slot 1 only holds a word at occupancy 2.
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             armed_q, armed_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             pop;
    logic [4:0]       bit_nxt;
    entry_t           new_entry;

    assign din_ready  = (occ_q != 2'd2);
    assign enc_valid  = (occ_q != 2'd0);
    assign enc_data   = head_q.data;
    assign enc_parity = head_q.parity;
    assign inj_armed  = armed_q;
    assign inj_done   = done_q;
    assign word_cnt   = cnt_q;

    // Build the incoming entry: encode din and apply any pending injection mask.
    always_comb begin
        // NOTE: combinational logic uses blocking assignments, and every output gets a
        // default first so no path leaves it unassigned (which would infer a latch).
        accept    = din_valid && din_ready;
        bit_nxt   = inj_bit + 5'd1;   // 5-bit wrap gives (inj_bit+1) mod 32
        new_entry = '{data: din, parity: calc_parity(din), inj: 1'b0};
        if (accept && armed_q) begin
            new_entry.inj = 1'b1;
            unique case (inj_mode_e'(inj_mode))
                INJ_DATA1: new_entry.data = din ^ (32'd1 << inj_bit);
                INJ_DATA2: new_entry.data = din ^ (32'd1 << inj_bit) ^ (32'd1 << bit_nxt);
                INJ_CHECK: begin
                    // Index 7 addresses no check bit, so it flips nothing.
                    if (inj_bit[2:0] != 3'd7) begin
                        new_entry.parity[inj_bit[2:0]] = ~new_entry.parity[inj_bit[2:0]];
                    end
                end
                default: ;  // INJ_NONE: consume the arm without flipping anything
            endcase
        end
    end

    // Queue, injection and counter next-state.
    always_comb begin
        pop     = enc_valid && enc_ready;
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;

        case (occ_q)
            2'd0: begin
                if (accept) begin
                    head_d = new_entry;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                case ({accept, pop})
                    2'b10: begin
                        tail_d = new_entry;
                        occ_d  = 2'd2;
                    end
                    2'b01: occ_d = 2'd0;        // head keeps its value while empty
                    2'b11: head_d = new_entry;  // old head leaves, new word takes its place
                    default: ;
                endcase
            end
            2'd2: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = 2'd1;
                end
            end
            default: occ_d = occ_q;
        endcase

        // An arm that coincides with an accept while unarmed applies to the next word.
        if (accept && armed_q) begin
            armed_d = 1'b0;
        end else if (inj_arm) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end

        done_d = pop && head_q.inj;

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (pop && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset flushes the queue and any pending arm.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the queue storage is reset because enc_data/enc_parity expose the
            // head slot directly and must read 0 out of reset.
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= 2'd0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            armed_q <= armed_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
